min_unit_arbiter: RTL and testbench

- Shares one combinational 32-bit unsigned minimum unit between NREQ requesters.
- Each requester presents an operand pair (a, b) with valid/ready. The block grants one request per cycle in round-robin order, computes min(a, b), and returns the result with the requester ID through a one-deep registered response stage that accepts backpressure.
- Sits between compute clients and the shared comparator datapath in the arithmetic subsystem.

---
 rtl/min_arb_pkg.sv | 46 ++++
 rtl/word_min.sv | 23 ++
 rtl/min_unit_arbiter.sv | 99 +++++++++
 tb/tb_min_unit_arbiter.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/min_arb_pkg.sv
// Shared types and helpers for min_unit_arbiter.
// Contents:
//   DefNreq/DefW/DefIdw  default configuration (4 requesters, 32-bit words, 2-bit IDs)
//   MaxReq/PtrW          upper bound on requester count and width of an index into it
//   word_t/id_t          default-configuration word and response-ID types
//   rr_pick_t/rr_pick    round-robin winner search starting at a pointer
package min_arb_pkg;

  localparam int unsigned DefNreq = 4;
  localparam int unsigned DefW    = 32;
  localparam int unsigned DefIdw  = 2;

  localparam int unsigned MaxReq  = 16;
  localparam int unsigned PtrW    = 4;

  typedef logic [DefW-1:0]   word_t;
  typedef logic [DefIdw-1:0] id_t;

  typedef struct packed {
    logic            found;
    logic [PtrW-1:0] idx;
  } rr_pick_t;

  // Scan ptr, ptr+1, ... (mod nreq) and return the first valid index.
  // ptr must already be < nreq.
  function automatic rr_pick_t rr_pick(input logic [MaxReq-1:0] valid,
                                       input logic [PtrW-1:0]   ptr,
                                       input int unsigned       nreq);
    rr_pick_t    r;
    int unsigned j;
    r.found = 1'b0;
    r.idx   = '0;
    for (int unsigned k = 0; k < MaxReq; k++) begin
      if (k < nreq) begin
        j = 32'(ptr) + k;
        if (j >= nreq) j = j - nreq;
        if (!r.found && valid[j[PtrW-1:0]]) begin
          r.found = 1'b1;
          r.idx   = j[PtrW-1:0];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/word_min.sv
// Combinational W-bit unsigned min/max unit.
// Ports:
//   a, b  operands
//   op    0 = min (tie returns b), 1 = max (tie returns a)
//   y     result
module word_min #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         op,
  output logic [W-1:0] y
);

  logic sel;

  always_comb begin
    // Flipping the compare outcome turns min into max and moves the tie winner to a.
    sel = (b > a) ^ op;
    y   = sel ? a : b;
  end

endmodule

// File: rtl/min_unit_arbiter.sv
// Round-robin arbiter sharing one combinational min unit between NREQ requesters,
// with a one-deep registered response stage that accepts backpressure.
// Optional build macro: MIN_UNIT_ARBITER_MAX_EN enables per-requester max via req_op.
// Ports:
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready        per-requester handshake; req_ready is one-hot or zero
//   req_a/req_b                packed operands, requester i at [i*W +: W]
//   req_op                     0 = min, 1 = max (ignored unless the macro is defined)
//   resp_valid/resp_ready      response handshake
//   resp_data/resp_id          result and index of the served requester
// IDW must be at least $clog2(NREQ); NREQ must be in 2..16.
module min_unit_arbiter
  import min_arb_pkg::*;
#(
  parameter int unsigned NREQ = DefNreq,
  parameter int unsigned W    = DefW,
  parameter int unsigned IDW  = DefIdw
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ-1:0]   req_op,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [W-1:0]      resp_data,
  output logic [IDW-1:0]    resp_id
);

  logic            can_accept;
  logic            xfer;
  rr_pick_t        pick;
  logic [PtrW-1:0] rr_ptr;
  logic [PtrW-1:0] rr_ptr_next;
  logic [W-1:0]    a_sel;
  logic [W-1:0]    b_sel;
  logic            op_sel;
  logic [W-1:0]    result;

  always_comb begin
    can_accept = !resp_valid || resp_ready;
    pick       = rr_pick(MaxReq'(req_valid), rr_ptr, NREQ);
    xfer       = can_accept && pick.found;
    for (int unsigned i = 0; i < NREQ; i++) begin
      req_ready[i] = xfer && (pick.idx == PtrW'(i));
    end
    rr_ptr_next = (pick.idx == PtrW'(NREQ - 1)) ? '0 : pick.idx + PtrW'(1);
  end

  // Operand mux for the granted requester.
  always_comb begin
    a_sel  = '0;
    b_sel  = '0;
    op_sel = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pick.idx == PtrW'(i)) begin
        a_sel = req_a[i*W +: W];
        b_sel = req_b[i*W +: W];
`ifdef MIN_UNIT_ARBITER_MAX_EN
        op_sel = req_op[i];
`endif
      end
    end
  end

`ifndef MIN_UNIT_ARBITER_MAX_EN
  logic unused_req_op;
  assign unused_req_op = ^req_op;
`endif

  word_min #(
    .W (W)
  ) u_word_min (
    .a  (a_sel),
    .b  (b_sel),
    .op (op_sel),
    .y  (result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_id    <= '0;
      rr_ptr     <= '0;
    end else if (xfer) begin
      resp_valid <= 1'b1;
      resp_data  <= result;
      resp_id    <= IDW'(pick.idx);
      rr_ptr     <= rr_ptr_next;
    end else if (resp_ready) begin
      // Drain without refill: data and id hold their last values.
      resp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_min_unit_arbiter.sv
// Directed self-checking bench for min_unit_arbiter (default NREQ=4, W=32, IDW=2).
module tb_min_unit_arbiter;

  logic         clk;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_a;
  logic [127:0] req_b;
  logic [3:0]   req_op;
  logic         resp_valid;
  logic         resp_ready;
  logic [31:0]  resp_data;
  logic [1:0]   resp_id;

  int vectors;
  int miscompares;

  min_unit_arbiter #(
    .NREQ (4),
    .W    (32),
    .IDW  (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
  endtask

  // Advance past the next rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] exp_res [4];
  int          g;

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    req_valid   = 4'b0000;
    req_a       = '0;
    req_b       = '0;
    req_op      = 4'b0000;
    resp_ready  = 1'b1;

    // Reset state
    tick();
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_resp_id", 32'(resp_id), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b1;
    tick();

    // Single request from 0
    set_req(0, 32'h0000_0010, 32'h0000_0005);
    req_valid = 4'b0001;
    #1;
    chk("single_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = 4'b0000;
    chk("single_valid", 32'(resp_valid), 32'd1);
    chk("single_data", resp_data, 32'h5);
    chk("single_id", 32'(resp_id), 32'd0);
    tick();
    chk("drain_valid", 32'(resp_valid), 32'd0);
    chk("drain_data_hold", resp_data, 32'h5);

    // Streaming all four with boundary operands; rr_ptr is now 1
    set_req(0, 32'hFFFF_FFFF, 32'h0000_0000);
    set_req(1, 32'h8000_0000, 32'h8000_0000);
    set_req(2, 32'h7FFF_FFFF, 32'h8000_0000);
    set_req(3, 32'h0000_0003, 32'h0000_0009);
    exp_res[0] = 32'h0000_0000;
    exp_res[1] = 32'h8000_0000;
    exp_res[2] = 32'h7FFF_FFFF;
    exp_res[3] = 32'h0000_0003;
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      g = (1 + k) % 4;
      #1;
      chk("stream_ready", 32'(req_ready), 32'(1) << g);
      tick();
      chk("stream_valid", 32'(resp_valid), 32'd1);
      chk("stream_id", 32'(resp_id), 32'(g));
      chk("stream_data", resp_data, exp_res[g]);
    end

    // Backpressure: pending response from requester 1, rr_ptr is 2
    resp_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_ready", 32'(req_ready), 32'd0);
      tick();
      chk("bp_valid", 32'(resp_valid), 32'd1);
      chk("bp_id", 32'(resp_id), 32'd1);
      chk("bp_data", resp_data, 32'h8000_0000);
    end
    resp_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(req_ready), 32'h4);
    tick();
    req_valid = 4'b0000;
    chk("bp_release_id", 32'(resp_id), 32'd2);
    chk("bp_release_data", resp_data, 32'h7FFF_FFFF);
    tick();

    // Op select on requester 3 (a=3, b=9); rr_ptr is 3
    req_op    = 4'b1000;
    req_valid = 4'b1000;
    tick();
`ifdef MIN_UNIT_ARBITER_MAX_EN
    chk("op_max", resp_data, 32'd9);
`else
    chk("op_ignored", resp_data, 32'd3);
`endif
    chk("op_id", 32'(resp_id), 32'd3);
    req_op = 4'b0000;
    tick();
    chk("op_min", resp_data, 32'd3);
    req_valid = 4'b0000;
    tick();

    // rr_ptr wrapped to 0; grant 1 moves it to 2, then reset mid-response
    req_valid = 4'b0010;
    tick();
    req_valid = 4'b0000;
    chk("pre_rst_id", 32'(resp_id), 32'd1);
    chk("pre_rst_valid", 32'(resp_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(resp_valid), 32'd0);
    chk("async_rst_data", resp_data, 32'd0);
    tick();
    rst_n = 1'b1;
    req_valid = 4'b0101;
    #1;
    chk("post_rst_ready", 32'(req_ready), 32'h1);
    tick();
    chk("post_rst_id", 32'(resp_id), 32'd0);
    chk("post_rst_data", resp_data, 32'h0);
    #1;
    chk("post_rst_ready2", 32'(req_ready), 32'h4);
    tick();
    req_valid = 4'b0000;
    chk("post_rst_id2", 32'(resp_id), 32'd2);
    chk("post_rst_data2", resp_data, 32'h7FFF_FFFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
